// File: rtl/pipeline_ctrl.sv
// Hazard and stall/bubble controller for the 5-stage pipeline: load-use interlock,
// redirect flush, data-memory wait handling with timeout, and saturating perf counters.
module pipeline_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       id_Ra,
    input  logic [4:0]       id_Rb,
    input  logic             id_useRa,
    input  logic             id_useRb,
    input  logic             ex_MemtoReg,
    input  logic             ex_RegWr,
    input  logic [4:0]       ex_Rw,
    input  logic             mem_Branch,
    input  logic             mem_Zero,
    input  logic             mem_Jump,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exmem_stall,
    output logic             memwb_stall,
    output logic             ifid_bubble,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             memwb_bubble,
    output logic             redirect,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(WAIT_MAX + 2);
    localparam logic [WC_W-1:0] WAIT_LIM = WC_W'(WAIT_MAX);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WC_W-1:0]   wait_cnt;
    logic [WC_W-1:0]   wait_cnt_next;
    logic [WC_W-1:0]   wait_cnt_inc;
    logic              mw;
    logic              rd;
    logic              lu;
    logic              stall_take;
    logic              flush_take;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign mw = mem_req & ~mem_ready;
    assign rd = (mem_Branch & mem_Zero) | mem_Jump;
    assign lu = ex_MemtoReg & ex_RegWr & (ex_Rw != 5'd0) &
                ((id_useRa & (id_Ra == ex_Rw)) | (id_useRb & (id_Rb == ex_Rw)));
    assign wait_cnt_inc = wait_cnt + WC_W'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            err      <= (state_next == ST_ERR);
        end
    end

    // wait_cnt holds the number of consecutive wait cycles already completed
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_RUN: begin
                if (mw) begin
                    wait_cnt_next = WC_W'(1);
                    state_next    = (WAIT_LIM <= WC_W'(1)) ? ST_ERR : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!mw) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_inc;
                    if (wait_cnt_inc >= WAIT_LIM) begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                state_next = ST_ERR;
            end
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        idex_stall   = 1'b0;
        exmem_stall  = 1'b0;
        memwb_stall  = 1'b0;
        ifid_bubble  = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        memwb_bubble = 1'b0;
        redirect     = 1'b0;
        stall_take   = 1'b0;
        flush_take   = 1'b0;
        if (!Reset) begin
            if (state == ST_ERR || mw) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
                memwb_stall = 1'b1;
            end else if (rd) begin
                redirect     = 1'b1;
                ifid_bubble  = 1'b1;
                idex_bubble  = 1'b1;
                exmem_bubble = 1'b1;
                flush_take   = 1'b1;
            end else if (lu) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
                stall_take  = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_take) stall_cnt <= sat_inc(stall_cnt);
            if (flush_take) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a counting reference model.
module tb_pipeline_ctrl;

    localparam int WMAX    = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [4:0]    id_Ra, id_Rb, ex_Rw;
    logic          id_useRa, id_useRb, ex_MemtoReg, ex_RegWr;
    logic          mem_Branch, mem_Zero, mem_Jump, mem_req, mem_ready;
    logic          pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
    logic          ifid_bubble, idex_bubble, exmem_bubble, memwb_bubble;
    logic          redirect, err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    // reference model state: plain counts, no encoding
    int m_wait   = 0;
    int m_stall  = 0;
    int m_flush  = 0;
    bit m_err    = 1'b0;
    bit started  = 1'b0;

    pipeline_ctrl #(.WAIT_MAX(WMAX), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset),
        .id_Ra(id_Ra), .id_Rb(id_Rb), .id_useRa(id_useRa), .id_useRb(id_useRb),
        .ex_MemtoReg(ex_MemtoReg), .ex_RegWr(ex_RegWr), .ex_Rw(ex_Rw),
        .mem_Branch(mem_Branch), .mem_Zero(mem_Zero), .mem_Jump(mem_Jump),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
        .ifid_bubble(ifid_bubble), .idex_bubble(idex_bubble),
        .exmem_bubble(exmem_bubble), .memwb_bubble(memwb_bubble),
        .redirect(redirect), .err(err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 Clk = ~Clk;

    function automatic bit f_mw();
        return mem_req && !mem_ready;
    endfunction

    function automatic bit f_rd();
        return (mem_Branch && mem_Zero) || mem_Jump;
    endfunction

    function automatic bit f_lu();
        bit hit;
        hit = (id_useRa && id_Ra == ex_Rw) || (id_useRb && id_Rb == ex_Rw);
        return ex_MemtoReg && ex_RegWr && ex_Rw != 0 && hit;
    endfunction

    // bit order: 5 stalls (pc..memwb), 4 bubbles (ifid..memwb), redirect, err
    function automatic logic [10:0] exp_outs();
        logic [10:0] o;
        o = '0;
        if (!Reset) begin
            if (m_err || f_mw()) o[10:6] = 5'b11111;
            else if (f_rd()) begin o[5:3] = 3'b111; o[1] = 1'b1; end
            else if (f_lu()) begin o[10] = 1'b1; o[9] = 1'b1; o[4] = 1'b1; end
        end
        o[0] = m_err;
        return o;
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        end else if (!m_err) begin
            if (f_mw()) begin
                m_wait++;
                if (m_wait >= WMAX) m_err = 1;
            end else begin
                m_wait = 0;
                if (f_rd()) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
                else if (f_lu()) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
            end
        end
        started = 1'b1;
    end

    always @(negedge Clk) begin
        logic [10:0] got, want;
        if (started) begin
            got  = {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
                    ifid_bubble, idex_bubble, exmem_bubble, memwb_bubble, redirect, err};
            want = exp_outs();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL outs @%0t: got %b expected %b", $time, got, want);
            end
            tests++;
            if (int'(stall_cnt) != m_stall || ^stall_cnt === 1'bx) begin
                fails++;
                $display("FAIL stall_cnt @%0t: got %0d expected %0d", $time, stall_cnt, m_stall);
            end
            tests++;
            if (int'(flush_cnt) != m_flush || ^flush_cnt === 1'bx) begin
                fails++;
                $display("FAIL flush_cnt @%0t: got %0d expected %0d", $time, flush_cnt, m_flush);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        id_Ra = 0; id_Rb = 0; id_useRa = 0; id_useRb = 0;
        ex_MemtoReg = 0; ex_RegWr = 0; ex_Rw = 0;
        mem_Branch = 0; mem_Zero = 0; mem_Jump = 0;
        mem_req = 0; mem_ready = 1;
    endtask

    task automatic set_lu(input logic [4:0] rw);
        ex_MemtoReg = 1; ex_RegWr = 1; ex_Rw = rw; id_Ra = 5; id_useRa = 1;
    endtask

    task automatic do_reset();
        Reset = 1; tick(); Reset = 0;
    endtask

    initial begin
        idle();
        Reset = 1;
        tick(); tick();
        @(negedge Clk);
        chk("reset_err", int'(err), 0);
        chk("reset_stall_cnt", int'(stall_cnt), 0);
        Reset = 0;
        tick();

        // load-use for one cycle
        set_lu(5);
        @(negedge Clk);
        chk("lu_pc_stall", int'(pc_stall), 1);
        chk("lu_ifid_stall", int'(ifid_stall), 1);
        chk("lu_idex_bubble", int'(idex_bubble), 1);
        tick(); idle(); set_lu(0);
        @(negedge Clk);
        chk("lu_cnt_after", int'(stall_cnt), 1);
        chk("lu_rw0_pc_stall", int'(pc_stall), 0);
        chk("lu_rw0_idex_bubble", int'(idex_bubble), 0);

        // taken branch masks a load-use
        tick(); set_lu(5); mem_Branch = 1; mem_Zero = 1;
        @(negedge Clk);
        chk("br_redirect", int'(redirect), 1);
        chk("br_bubbles", int'({ifid_bubble, idex_bubble, exmem_bubble}), 7);
        chk("br_no_stall", int'(pc_stall | ifid_stall), 0);
        tick(); mem_Zero = 0; mem_Branch = 1; ex_MemtoReg = 0;
        @(negedge Clk);
        chk("br_flush_cnt", int'(flush_cnt), 1);
        chk("br_stall_cnt", int'(stall_cnt), 1);
        chk("br_nz_redirect", int'(redirect), 0);

        // 3-cycle memory wait
        tick(); idle(); mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("mw_stalls", int'({pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall}), 31);
            tick();
        end
        mem_ready = 1;
        @(negedge Clk);
        chk("mw_done_stall", int'(pc_stall), 0);
        tick(); idle();
        @(negedge Clk);
        chk("mw_err", int'(err), 0);

        // jump pending during a 2-cycle wait
        mem_Jump = 1; mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            chk("jw_redirect_held", int'(redirect), 0);
            tick();
        end
        mem_ready = 1;
        @(negedge Clk);
        chk("jw_redirect", int'(redirect), 1);
        tick(); idle();

        // timeout after WMAX wait cycles
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < WMAX; i++) tick();
        @(negedge Clk);
        chk("to_err", int'(err), 1);
        tick(); tick(); mem_ready = 1;
        @(negedge Clk);
        chk("to_err_stall", int'(memwb_stall), 1);
        Reset = 1;
        @(negedge Clk);
        chk("to_reset_stall", int'(pc_stall), 0);
        tick(); Reset = 0; idle();
        @(negedge Clk);
        chk("to_cleared", int'(err), 0);

        // counter saturation
        set_lu(5);
        for (int i = 0; i < 20; i++) tick();
        idle();
        @(negedge Clk);
        chk("sat_stall_cnt", int'(stall_cnt), 15);
        do_reset();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            Reset       = ($urandom_range(0, 99) == 0);
            id_Ra       = 5'($urandom_range(0, 3));
            id_Rb       = 5'($urandom_range(0, 3));
            ex_Rw       = 5'($urandom_range(0, 3));
            id_useRa    = 1'($urandom_range(0, 1));
            id_useRb    = 1'($urandom_range(0, 1));
            ex_MemtoReg = 1'($urandom_range(0, 1));
            ex_RegWr    = 1'($urandom_range(0, 1));
            mem_Branch  = ($urandom_range(0, 3) == 0);
            mem_Zero    = 1'($urandom_range(0, 1));
            mem_Jump    = ($urandom_range(0, 9) == 0);
            mem_req     = ($urandom_range(0, 9) < 4);
            mem_ready   = ($urandom_range(0, 9) < 6);
            tick();
        end
        idle();
        tick();
        @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
